rename_freelist_arbiter: RTL and testbench
==========================================

# rename_freelist_arbiter

Allocation/release controller for the four interleaved physical-register freelist banks. Bank k holds pregs with preg[1:0]==k. Sits between the rename stage, the commit stage and the bank instances. Each cycle it:
- grants up to two pregs to the rename slots, round-robin across non-empty banks;
- steers up to two committed frees to their home banks through a small pending buffer;
- sequences a flush (bank clean plus settle) on pipeline recovery.

## Interface
Parameters:
- BANKS, 4, number of freelist banks; fixed power of two, bank index = preg[1:0]
- PREGW, 7, physical register tag width
- PENDDEEP, 4, pending-free buffer entries

Ports:
- Clk  in  1  clock
- Rest  in  1  reset; one clock, synchronous, active-high
- AllocReq  in  2  rename slot requests, bit0 = older slot
- AllocGrant  out  2  slot granted this cycle
- AllocPreg0, AllocPreg1  out  PREGW  granted tags; valid only with the grant bit
- AllocStall  out  1  some requesting slot was not granted
- BankEmpty  in  BANKS  per-bank empty flag
- BankPreOut  in  BANKS*PREGW  per-bank head tag, combinational preview
- BankRable  out  BANKS  pop strobe; the bank advances on the next edge
- BankWable  out  BANKS  push strobe
- BankDin  out  BANKS*PREGW  push data
- BankClean  out  BANKS  refill banks to their initial contents
- FreeValid  in  2  commit frees
- FreePreg0, FreePreg1  in  PREGW  freed tags
- FreeReady  out  1  commit may present frees this cycle
- Flush  in  1  recovery request, one cycle

## Operation
- FSM states: RUN, SETTLE.
  - Reset enters SETTLE.
  - SETTLE always goes to RUN on the next cycle.
  - Flush in any state drives BankClean=all-ones in that cycle, empties the pending buffer, drops current frees and goes to SETTLE.
  - No grants in SETTLE, nor in any cycle where Flush=1.
- Allocation, RUN only:
  - Candidate order is RrPtr, RrPtr+1, … mod 4, skipping banks with BankEmpty=1.
  - Slot0 takes the first candidate; slot1 takes the next distinct candidate.
  - Grants are in order. If slot0 requests and no candidate exists, neither slot is granted. If slot0 does not request, slot1 takes the first candidate.
  - The granted bank's BankRable=1 and AllocPregN = that bank's BankPreOut, in the same cycle.
  - RrPtr <= (last granted bank + 1) mod 4. RrPtr is unchanged when there is no grant.
  - AllocStall = |(AllocReq & ~AllocGrant) in every state.
- Release:
  - Frees with tag 0 are dropped.
  - Each bank takes at most one push per cycle.
  - Service order: pending entries oldest first, then FreePreg0, then FreePreg1.
  - Losers (bank already pushed this cycle) are appended to the pending buffer in that order.
  - Pending drain and new frees are both active in RUN and SETTLE.
- FreeReady=1 iff the pending buffer has ≥2 free entries at cycle start. Commit must not assert FreeValid when FreeReady=0. Overflow is a protocol violation: assertion fires, entry is lost.
- A same-cycle pop and push on one bank are both issued; the bank handles them independently.

## Timing
- Grant latency is 0: AllocGrant and AllocPreg are combinational from AllocReq, BankEmpty, BankPreOut and RrPtr.
- A pushed tag is poppable no earlier than the cycle after BankEmpty deasserts. Same-cycle bypass of a free to an allocation is not done.
- Flush timing:
  - cycle F: BankClean=1, no grants/pushes;
  - F+1: SETTLE, no grants;
  - F+2: RUN, grants allowed.
- Flush during SETTLE re-cleans and stays in SETTLE one more cycle.
- Reset values, while Rest=1 and in the cycle after:
  - AllocGrant=0, AllocStall=|AllocReq, BankRable=0, BankWable=0, BankClean=0, BankDin=0, FreeReady=1;
  - RrPtr=0, pending buffer empty, state=SETTLE.
- Rest asserted mid-operation discards pending frees without pushing them.

## Structure
- Shared package `rename_pkg`: BANKS, PREGW, PENDDEEP, bank-index function (preg[1:0]), FSM state enum {RUN, SETTLE}.
- One sub-module, `free_pending_buf`:
  - PENDDEEP-entry, order-preserving buffer of tags;
  - per-entry bank-conflict drain (removes any serviced entries and compacts);
  - up to 2 appends per cycle;
  - exposes its free-entry count.
- Top level holds the FSM, the round-robin find-first over rotated BankEmpty, and write steering.

## Test plan
- Reset, then RUN. Banks all non-empty, heads {b0:32, b1:33, b2:34, b3:35}, RrPtr=0, AllocReq=11 → Grant=11, Preg0=32, Preg1=33, BankRable=0011. Next cycle RrPtr=2.
- Empty skipping: BankEmpty=0101, RrPtr=0, AllocReq=11 → slot0 bank1, slot1 bank3, Rable=1010, RrPtr→0.
- In-order stall: all banks empty, AllocReq=11 → Grant=00, Stall=1. Only bank2 non-empty, AllocReq=11 → Grant=01, Stall=1.
- Same-bank frees: FreePreg0=37, FreePreg1=41 (both bank1) → cycle 1: Wable bank1 with Din=37, pending=1. Cycle 2: Wable bank1 with Din=41. FreePreg=0 never pushed.
- Backpressure: repeated same-bank free pairs → FreeReady drops to 0 once 3 entries are pending; no entry is lost or reordered per bank.
- Flush with 2 pending frees and AllocReq=11 → F: BankClean=1111, Grant=00, pending cleared. F+1: Grant=00. F+2: grants resume. Flush at F+1 extends SETTLE to F+2.

Source files
------------

// File: rtl/rename_pkg.sv
// rename_pkg: shared sizes, preg-to-bank helper and FSM state type for the rename freelist arbiter (no ports)
package rename_pkg;
  localparam int BANKS = 4;
  localparam int PREGW = 7;
  localparam int PENDDEEP = 4;
  localparam int BANKBITS = $clog2(BANKS);
  typedef enum logic {RUN = 1'b0, SETTLE = 1'b1} state_e;
  function automatic logic [BANKBITS-1:0] bank_of(input logic [PREGW-1:0] p);
    return p[BANKBITS-1:0];
  endfunction
endpackage

// File: rtl/free_pending_buf.sv
// free_pending_buf: order-preserving pending-free tag buffer; clk/rst/clr, drain mask removes serviced entries and compacts, app_vld/app_tag0/app_tag1 append up to two, tags/vld/free_cnt expose contents
module free_pending_buf #(
  parameter int PREGW = 7,
  parameter int PENDDEEP = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic [PENDDEEP-1:0]         drain,
  input  logic [1:0]                  app_vld,
  input  logic [PREGW-1:0]            app_tag0,
  input  logic [PREGW-1:0]            app_tag1,
  output logic [PENDDEEP*PREGW-1:0]   tags,
  output logic [PENDDEEP-1:0]         vld,
  output logic [$clog2(PENDDEEP+1)-1:0] free_cnt
);
  localparam int CW = $clog2(PENDDEEP + 1);
  localparam int AW = $clog2(PENDDEEP);
  logic [PREGW-1:0] mem [PENDDEEP];
  logic [PREGW-1:0] nmem [PENDDEEP];
  logic [CW-1:0] cnt, ncnt;
  logic ovf;
  always_comb begin
    for (int i = 0; i < PENDDEEP; i++) begin
      vld[i] = CW'(i) < cnt;
      tags[i*PREGW +: PREGW] = mem[i];
    end
  end
  assign free_cnt = CW'(PENDDEEP) - cnt;
  always_comb begin : compact
    int k;
    nmem = mem;
    ovf = 1'b0;
    k = 0;
    for (int i = 0; i < PENDDEEP; i++)
      if (vld[i] && !drain[i]) begin
        nmem[AW'(k)] = mem[i];
        k++;
      end
    for (int j = 0; j < 2; j++)
      if (app_vld[j]) begin
        if (k < PENDDEEP) begin
          nmem[AW'(k)] = j == 0 ? app_tag0 : app_tag1;
          k++;
        end else ovf = 1'b1;
      end
    ncnt = clr ? '0 : CW'(k);
  end
  always_ff @(posedge clk) begin
    cnt <= rst ? '0 : ncnt;
    mem <= nmem;
    assert (rst || !ovf);
  end
endmodule

// File: rtl/rename_freelist_arbiter.sv
// rename_freelist_arbiter: round-robin preg grants to two rename slots, commit-free steering to home banks via a pending buffer, flush/settle sequencing; Clk/Rest, AllocReq/AllocGrant/AllocPreg0/1/AllocStall, Bank* strobes and data, FreeValid/FreePreg0/1/FreeReady, Flush
module rename_freelist_arbiter
  import rename_pkg::*;
#(
  parameter int BANKS = rename_pkg::BANKS,
  parameter int PREGW = rename_pkg::PREGW,
  parameter int PENDDEEP = rename_pkg::PENDDEEP
) (
  input  logic                     Clk,
  input  logic                     Rest,
  input  logic [1:0]               AllocReq,
  output logic [1:0]               AllocGrant,
  output logic [PREGW-1:0]         AllocPreg0,
  output logic [PREGW-1:0]         AllocPreg1,
  output logic                     AllocStall,
  input  logic [BANKS-1:0]         BankEmpty,
  input  logic [BANKS*PREGW-1:0]   BankPreOut,
  output logic [BANKS-1:0]         BankRable,
  output logic [BANKS-1:0]         BankWable,
  output logic [BANKS*PREGW-1:0]   BankDin,
  output logic [BANKS-1:0]         BankClean,
  input  logic [1:0]               FreeValid,
  input  logic [PREGW-1:0]         FreePreg0,
  input  logic [PREGW-1:0]         FreePreg1,
  output logic                     FreeReady,
  input  logic                     Flush
);
  localparam int BI = $clog2(BANKS);
  localparam int CW = $clog2(PENDDEEP + 1);
  state_e state;
  logic [BI-1:0] rr, c0, c1, b1;
  logic h0, h1, run;
  logic [PENDDEEP-1:0] pvld, drain;
  logic [PENDDEEP*PREGW-1:0] ptag;
  logic [CW-1:0] pfree;
  logic [1:0] app;
  assign run = state == RUN && !Flush && !Rest;
  always_comb begin : find
    logic [BI-1:0] b;
    b = '0;
    h0 = 1'b0;
    h1 = 1'b0;
    c0 = '0;
    c1 = '0;
    for (int i = 0; i < BANKS; i++) begin
      b = rr + BI'(i);
      if (!BankEmpty[b]) begin
        if (!h0) begin
          h0 = 1'b1;
          c0 = b;
        end else if (!h1) begin
          h1 = 1'b1;
          c1 = b;
        end
      end
    end
  end
  // slot1 may only pass slot0 when slot0 is idle; an ungranted slot0 blocks both
  assign AllocGrant[0] = run && AllocReq[0] && h0;
  assign AllocGrant[1] = run && AllocReq[1] && h0 && (!AllocReq[0] || h1);
  assign b1 = AllocReq[0] ? c1 : c0;
  assign AllocPreg0 = AllocGrant[0] ? BankPreOut[c0*PREGW +: PREGW] : '0;
  assign AllocPreg1 = AllocGrant[1] ? BankPreOut[b1*PREGW +: PREGW] : '0;
  assign BankRable = ({BANKS{AllocGrant[0]}} & (BANKS'(1) << c0)) |
                     ({BANKS{AllocGrant[1]}} & (BANKS'(1) << b1));
  assign AllocStall = |(AllocReq & ~AllocGrant);
  assign BankClean = {BANKS{Flush && !Rest}};
  assign FreeReady = Rest || pfree >= CW'(2);
  // oldest pending first, then the two new frees; a bank already written this cycle turns a free into a pending append
  always_comb begin : steer
    logic [BANKS-1:0] taken;
    logic [PREGW-1:0] t;
    logic v;
    taken = '0;
    t = '0;
    v = 1'b0;
    BankDin = '0;
    drain = '0;
    app = '0;
    if (!Flush && !Rest) begin
      for (int i = 0; i < PENDDEEP; i++) begin
        t = ptag[i*PREGW +: PREGW];
        if (pvld[i] && !taken[bank_of(t)]) begin
          taken[bank_of(t)] = 1'b1;
          BankDin[bank_of(t)*PREGW +: PREGW] = t;
          drain[i] = 1'b1;
        end
      end
      for (int j = 0; j < 2; j++) begin
        t = j == 0 ? FreePreg0 : FreePreg1;
        v = FreeValid[j] && t != '0;
        if (v && !taken[bank_of(t)]) begin
          taken[bank_of(t)] = 1'b1;
          BankDin[bank_of(t)*PREGW +: PREGW] = t;
        end else app[j] = v;
      end
    end
    BankWable = taken;
  end
  free_pending_buf #(.PREGW(PREGW), .PENDDEEP(PENDDEEP)) u_pend (
    .clk(Clk),
    .rst(Rest),
    .clr(Flush),
    .drain(drain),
    .app_vld(app),
    .app_tag0(FreePreg0),
    .app_tag1(FreePreg1),
    .tags(ptag),
    .vld(pvld),
    .free_cnt(pfree)
  );
  always_ff @(posedge Clk) begin
    if (Rest) begin
      state <= SETTLE;
      rr <= '0;
    end else begin
      state <= Flush ? SETTLE : RUN;
      rr <= AllocGrant[1] ? b1 + 1'b1 : AllocGrant[0] ? c0 + 1'b1 : rr;
    end
  end
endmodule

// File: tb/tb_rename_freelist_arbiter.sv
// tb_rename_freelist_arbiter: directed scenarios with a per-bank push scoreboard for rename_freelist_arbiter
module tb_rename_freelist_arbiter;
  logic Clk = 1'b0;
  logic Rest = 1'b1;
  logic Flush = 1'b0;
  logic [1:0] AllocReq = 2'b00;
  logic [1:0] FreeValid = 2'b00;
  logic [6:0] FreePreg0 = '0;
  logic [6:0] FreePreg1 = '0;
  logic [3:0] BankEmpty = 4'b0000;
  logic [1:0] AllocGrant;
  logic [6:0] AllocPreg0, AllocPreg1;
  logic AllocStall, FreeReady;
  logic [3:0] BankRable, BankWable, BankClean;
  logic [27:0] BankPreOut, BankDin;
  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0] sb[$];

  assign BankPreOut = {7'd35, 7'd34, 7'd33, 7'd32};
  always #5 Clk = ~Clk;

  rename_freelist_arbiter dut (
    .Clk(Clk), .Rest(Rest),
    .AllocReq(AllocReq), .AllocGrant(AllocGrant),
    .AllocPreg0(AllocPreg0), .AllocPreg1(AllocPreg1), .AllocStall(AllocStall),
    .BankEmpty(BankEmpty), .BankPreOut(BankPreOut),
    .BankRable(BankRable), .BankWable(BankWable), .BankDin(BankDin), .BankClean(BankClean),
    .FreeValid(FreeValid), .FreePreg0(FreePreg0), .FreePreg1(FreePreg1),
    .FreeReady(FreeReady), .Flush(Flush)
  );

  always @(negedge Clk)
    if (!Rest)
      for (int b = 0; b < 4; b++)
        if (BankWable[b]) begin
          int idx;
          idx = -1;
          foreach (sb[i]) if (idx < 0 && sb[i][1:0] == 2'(b)) idx = i;
          n_cmp++;
          if (idx < 0) begin
            n_bad++;
            $display("FAIL push_unexpected bank%0d got=%0d required=none", b, BankDin[b*7 +: 7]);
          end else begin
            if (BankDin[b*7 +: 7] !== sb[idx]) begin
              n_bad++;
              $display("FAIL push_order bank%0d got=%0d required=%0d", b, BankDin[b*7 +: 7], sb[idx]);
            end
            sb.delete(idx);
          end
        end

  initial begin
    #200000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rest = 1'b1;
    AllocReq = 2'b11;
    tick();
    tick();
    @(negedge Clk);
    n_cmp++;
    if ({AllocGrant, AllocStall, BankRable, BankWable, BankClean} !== {2'b00, 1'b1, 4'b0, 4'b0, 4'b0}) begin
      n_bad++;
      $display("FAIL rst_ctrl got=%b required=%b", {AllocGrant, AllocStall, BankRable, BankWable, BankClean}, 15'b001000000000000);
    end
    n_cmp++;
    if ({BankDin, FreeReady} !== {28'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL rst_din_ready got=%h required=%h", {BankDin, FreeReady}, 29'd1);
    end
    tick();
    Rest = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if ({AllocGrant, AllocStall, BankRable, FreeReady} !== {2'b00, 1'b1, 4'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL rst_settle got=%b required=%b", {AllocGrant, AllocStall, BankRable, FreeReady}, 8'b00100001);
    end
    tick();
    AllocReq = 2'b00;
  endtask

  task automatic test_alloc_basic();
    AllocReq = 2'b11;
    @(negedge Clk);
    n_cmp++;
    if ({AllocGrant, AllocStall, BankRable} !== {2'b11, 1'b0, 4'b0011}) begin
      n_bad++;
      $display("FAIL alloc_pair got=%b required=%b", {AllocGrant, AllocStall, BankRable}, 7'b1100011);
    end
    n_cmp++;
    if ({AllocPreg0, AllocPreg1} !== {7'd32, 7'd33}) begin
      n_bad++;
      $display("FAIL alloc_pair_tags got=%0d,%0d required=32,33", AllocPreg0, AllocPreg1);
    end
    tick();
    AllocReq = 2'b01;
    @(negedge Clk);
    n_cmp++;
    if ({AllocGrant, BankRable, AllocPreg0} !== {2'b01, 4'b0100, 7'd34}) begin
      n_bad++;
      $display("FAIL alloc_rr2 got=%b/%b/%0d required=01/0100/34", AllocGrant, BankRable, AllocPreg0);
    end
    tick();
    AllocReq = 2'b10;
    @(negedge Clk);
    n_cmp++;
    if ({AllocGrant, BankRable, AllocPreg1} !== {2'b10, 4'b1000, 7'd35}) begin
      n_bad++;
      $display("FAIL alloc_slot1_only got=%b/%b/%0d required=10/1000/35", AllocGrant, BankRable, AllocPreg1);
    end
    tick();
    AllocReq = 2'b00;
  endtask

  task automatic test_skip();
    BankEmpty = 4'b0101;
    AllocReq = 2'b11;
    @(negedge Clk);
    n_cmp++;
    if ({AllocGrant, BankRable, AllocPreg0, AllocPreg1} !== {2'b11, 4'b1010, 7'd33, 7'd35}) begin
      n_bad++;
      $display("FAIL skip_empty got=%b/%b/%0d/%0d required=11/1010/33/35", AllocGrant, BankRable, AllocPreg0, AllocPreg1);
    end
    tick();
    BankEmpty = 4'b0000;
    AllocReq = 2'b01;
    @(negedge Clk);
    n_cmp++;
    if ({AllocGrant, BankRable, AllocPreg0} !== {2'b01, 4'b0001, 7'd32}) begin
      n_bad++;
      $display("FAIL skip_rr_wrap got=%b/%b/%0d required=01/0001/32", AllocGrant, BankRable, AllocPreg0);
    end
    tick();
    AllocReq = 2'b00;
  endtask

  task automatic test_stall();
    BankEmpty = 4'b1111;
    AllocReq = 2'b11;
    @(negedge Clk);
    n_cmp++;
    if ({AllocGrant, AllocStall, BankRable} !== {2'b00, 1'b1, 4'b0000}) begin
      n_bad++;
      $display("FAIL stall_all_empty got=%b required=%b", {AllocGrant, AllocStall, BankRable}, 7'b0010000);
    end
    tick();
    BankEmpty = 4'b1011;
    @(negedge Clk);
    n_cmp++;
    if ({AllocGrant, AllocStall, BankRable, AllocPreg0} !== {2'b01, 1'b1, 4'b0100, 7'd34}) begin
      n_bad++;
      $display("FAIL stall_in_order got=%b/%b/%b/%0d required=01/1/0100/34", AllocGrant, AllocStall, BankRable, AllocPreg0);
    end
    tick();
    BankEmpty = 4'b0000;
    AllocReq = 2'b00;
    @(negedge Clk);
    n_cmp++;
    if ({AllocGrant, AllocStall} !== 3'b000) begin
      n_bad++;
      $display("FAIL stall_idle got=%b required=000", {AllocGrant, AllocStall});
    end
    tick();
  endtask

  task automatic test_same_bank();
    FreeValid = 2'b11;
    FreePreg0 = 7'd37;
    FreePreg1 = 7'd41;
    sb.push_back(7'd37);
    sb.push_back(7'd41);
    @(negedge Clk);
    n_cmp++;
    if ({BankWable, BankDin[13:7], FreeReady} !== {4'b0010, 7'd37, 1'b1}) begin
      n_bad++;
      $display("FAIL same_bank_c1 got=%b/%0d/%b required=0010/37/1", BankWable, BankDin[13:7], FreeReady);
    end
    tick();
    FreeValid = 2'b00;
    @(negedge Clk);
    n_cmp++;
    if ({BankWable, BankDin[13:7]} !== {4'b0010, 7'd41}) begin
      n_bad++;
      $display("FAIL same_bank_c2 got=%b/%0d required=0010/41", BankWable, BankDin[13:7]);
    end
    tick();
    FreeValid = 2'b11;
    FreePreg0 = 7'd0;
    FreePreg1 = 7'd6;
    sb.push_back(7'd6);
    @(negedge Clk);
    n_cmp++;
    if ({BankWable, BankDin[20:14]} !== {4'b0100, 7'd6}) begin
      n_bad++;
      $display("FAIL zero_tag_drop got=%b/%0d required=0100/6", BankWable, BankDin[20:14]);
    end
    tick();
    FreeValid = 2'b00;
    @(negedge Clk);
    n_cmp++;
    if (BankWable !== 4'b0000) begin
      n_bad++;
      $display("FAIL zero_tag_idle got=%b required=0000", BankWable);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int sent, low_at;
    sent = 0;
    low_at = -1;
    for (int c = 0; c < 30 && (sent < 4 || sb.size() != 0); c++) begin
      if (!FreeReady && low_at < 0) low_at = c;
      if (FreeReady && sent < 4) begin
        FreeValid = 2'b11;
        FreePreg0 = 7'(8 * sent + 3);
        FreePreg1 = 7'(8 * sent + 7);
        sb.push_back(FreePreg0);
        sb.push_back(FreePreg1);
        sent++;
      end else FreeValid = 2'b00;
      tick();
    end
    FreeValid = 2'b00;
    n_cmp++;
    if (low_at !== 3) begin
      n_bad++;
      $display("FAIL bp_ready_low_cycle got=%0d required=3", low_at);
    end
    n_cmp++;
    if (sent !== 4 || sb.size() !== 0) begin
      n_bad++;
      $display("FAIL bp_drain got=sent%0d/left%0d required=sent4/left0", sent, sb.size());
    end
    @(negedge Clk);
    n_cmp++;
    if ({FreeReady, BankWable} !== {1'b1, 4'b0000}) begin
      n_bad++;
      $display("FAIL bp_idle got=%b required=10000", {FreeReady, BankWable});
    end
    tick();
  endtask

  task automatic test_flush();
    FreeValid = 2'b11;
    FreePreg0 = 7'd4;
    FreePreg1 = 7'd8;
    sb.push_back(7'd4);
    sb.push_back(7'd8);
    tick();
    FreePreg0 = 7'd12;
    FreePreg1 = 7'd16;
    sb.push_back(7'd12);
    sb.push_back(7'd16);
    tick();
    sb.delete();
    FreePreg0 = 7'd20;
    FreePreg1 = 7'd24;
    Flush = 1'b1;
    AllocReq = 2'b11;
    @(negedge Clk);
    n_cmp++;
    if ({BankClean, AllocGrant, BankWable, AllocStall} !== {4'b1111, 2'b00, 4'b0000, 1'b1}) begin
      n_bad++;
      $display("FAIL flush_f got=%b required=%b", {BankClean, AllocGrant, BankWable, AllocStall}, 11'b11110000001);
    end
    tick();
    Flush = 1'b0;
    FreeValid = 2'b00;
    @(negedge Clk);
    n_cmp++;
    if ({BankClean, AllocGrant, BankWable, FreeReady} !== {4'b0000, 2'b00, 4'b0000, 1'b1}) begin
      n_bad++;
      $display("FAIL flush_f1 got=%b required=%b", {BankClean, AllocGrant, BankWable, FreeReady}, 11'b00000000001);
    end
    tick();
    @(negedge Clk);
    n_cmp++;
    if ({AllocGrant, AllocPreg0, AllocPreg1} !== {2'b11, 7'd35, 7'd32}) begin
      n_bad++;
      $display("FAIL flush_f2 got=%b/%0d/%0d required=11/35/32", AllocGrant, AllocPreg0, AllocPreg1);
    end
    tick();
    Flush = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if ({BankClean, AllocGrant} !== {4'b1111, 2'b00}) begin
      n_bad++;
      $display("FAIL reflush_f got=%b required=111100", {BankClean, AllocGrant});
    end
    tick();
    @(negedge Clk);
    n_cmp++;
    if ({BankClean, AllocGrant} !== {4'b1111, 2'b00}) begin
      n_bad++;
      $display("FAIL reflush_f1 got=%b required=111100", {BankClean, AllocGrant});
    end
    tick();
    Flush = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if ({BankClean, AllocGrant} !== {4'b0000, 2'b00}) begin
      n_bad++;
      $display("FAIL reflush_f2 got=%b required=000000", {BankClean, AllocGrant});
    end
    tick();
    @(negedge Clk);
    n_cmp++;
    if ({AllocGrant, AllocPreg0, AllocPreg1} !== {2'b11, 7'd33, 7'd34}) begin
      n_bad++;
      $display("FAIL reflush_f3 got=%b/%0d/%0d required=11/33/34", AllocGrant, AllocPreg0, AllocPreg1);
    end
    tick();
    AllocReq = 2'b00;
  endtask

  task automatic test_mid_reset();
    FreeValid = 2'b11;
    FreePreg0 = 7'd1;
    FreePreg1 = 7'd5;
    sb.push_back(7'd1);
    tick();
    FreeValid = 2'b00;
    Rest = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if ({BankWable, FreeReady} !== {4'b0000, 1'b1}) begin
      n_bad++;
      $display("FAIL midrst_hold got=%b required=00001", {BankWable, FreeReady});
    end
    tick();
    Rest = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if (BankWable !== 4'b0000) begin
      n_bad++;
      $display("FAIL midrst_discard got=%b required=0000", BankWable);
    end
    tick();
    @(negedge Clk);
    tick();
    n_cmp++;
    if (sb.size() !== 0) begin
      n_bad++;
      $display("FAIL sb_leftover got=%0d required=0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_alloc_basic();
    test_skip();
    test_stall();
    test_same_bank();
    test_backpressure();
    test_flush();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
